lsu_mem_port: RTL

LSU_MEM_PORT -- requirements
Module: lsu_mem_port

---
 rtl/lsu_pkg.sv | 44 ++++
 rtl/lsu_load_align.sv | 35 +++
 rtl/lsu_mem_port.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, constants and lane helpers for the LSU memory port
// Purpose: access size encoding, load-tracker entry layout, default RAM latency,
//          byte-lane write mask and alignment check used by lsu_mem_port and
//          lsu_load_align.
// Ports:   none (package).
package lsu_pkg;

  localparam int LSU_RAM_LAT_DEF = 2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_BAD  = 2'd3
  } lsu_size_e;

  // One in-flight load: what the aligner needs once doutb comes back.
  typedef struct packed {
    logic       valid;
    logic [2:0] off;
    lsu_size_e  size;
    logic       sgn;
    logic [4:0] rd;
  } lsu_trk_t;

  function automatic logic [7:0] lane_mask(input lsu_size_e size, input logic [2:0] off);
    case (size)
      SZ_BYTE: lane_mask = 8'h01 << off;
      SZ_HALF: lane_mask = 8'h03 << off;
      SZ_WORD: lane_mask = 8'h0F << off;
      default: lane_mask = 8'h00;
    endcase
  endfunction

  function automatic logic is_misaligned(input lsu_size_e size, input logic [2:0] off);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = off[0];
      SZ_WORD: is_misaligned = (off[1:0] != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - combinational lane extract and sign/zero extension for loads
// Purpose: pick the bytes of a 64-bit RAM doubleword starting at lane off and
//          extend them to 32 bits according to access size and signedness.
// Ports:   doutb  in  64  RAM read doubleword
//          off    in  3   starting byte lane
//          size   in  2   access size (lsu_size_e)
//          sgn    in  1   sign-extend byte/half when 1
//          data   out 32  aligned, extended load value
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [63:0] doutb,
  input  logic [2:0]  off,
  input  lsu_size_e   size,
  input  logic        sgn,
  output logic [31:0] data
);

  logic [7:0] b0, b1, b2, b3;

  // Lane indices wrap at 8; only aligned accesses reach here, so a wrapped
  // lane is never part of the returned value.
  always_comb begin
    b0 = doutb[{off,         3'b000} +: 8];
    b1 = doutb[{off + 3'd1,  3'b000} +: 8];
    b2 = doutb[{off + 3'd2,  3'b000} +: 8];
    b3 = doutb[{off + 3'd3,  3'b000} +: 8];
    case (size)
      SZ_BYTE: data = {{24{sgn & b0[7]}}, b0};
      SZ_HALF: data = {{16{sgn & b1[7]}}, b1, b0};
      default: data = {b3, b2, b1, b0};
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// rtl/lsu_mem_port.sv - load/store unit port onto a 64-bit dual-port RAM
// Purpose: accept byte/half/word loads and stores, drive the RAM write port
//          (addra/dina/wea) and read port (addrb), track loads through the RAM
//          latency, return aligned results, flag misaligned accesses, stall
//          loads that would read a doubleword still being written, and report
//          register hazards against in-flight loads.
// Ports:   clk, rstn (sync, active-low)
//          req_valid/req_ready handshake; req_store, req_size, req_signed,
//          req_addr, req_wdata, req_rd request fields
//          addra, dina, wea (write port); addrb, doutb (read port)
//          ld_valid, ld_rd, ld_data, misalign_err (results)
//          q_rs1, q_rs2 in, hazard out
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int RAM_LAT = LSU_RAM_LAT_DEF
)
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic [31:0] addra,
  output logic [63:0] dina,
  output logic [7:0]  wea,
  output logic [31:0] addrb,
  input  logic [63:0] doutb,
  output logic        ld_valid,
  output logic [4:0]  ld_rd,
  output logic [31:0] ld_data,
  output logic        misalign_err,
  input  logic [4:0]  q_rs1,
  input  logic [4:0]  q_rs2,
  output logic        hazard
);

  lsu_size_e  req_sz;
  logic [2:0] req_off;
  logic [28:0] req_idx;
  logic       mis;
  logic       accept;
  logic       raw_hit;

  // trk[k] holds the load accepted k+1 cycles ago; trk[RAM_LAT] lines up with doutb.
  lsu_trk_t    trk    [RAM_LAT+1];
  // Stores accepted in the last RAM_LAT cycles, for read-after-write stalls.
  logic        st_v   [RAM_LAT];
  logic [28:0] st_idx [RAM_LAT];

  logic [31:0] align_data;

  assign req_sz  = lsu_size_e'(req_size);
  assign req_off = req_addr[2:0];
  assign req_idx = req_addr[31:3];
  assign mis     = is_misaligned(req_sz, req_off);
  assign accept  = req_valid & req_ready;

  always_comb begin
    raw_hit = 1'b0;
    for (int i = 0; i < RAM_LAT; i++) begin
      if (st_v[i] && (st_idx[i] == req_idx)) raw_hit = 1'b1;
    end
  end

  assign req_ready = ~(req_valid & ~req_store & raw_hit);

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i <= RAM_LAT; i++) begin
      if (trk[i].valid && (trk[i].rd != 5'd0) &&
          ((trk[i].rd == q_rs1) || (trk[i].rd == q_rs2)))
        hazard = 1'b1;
    end
  end

  lsu_load_align u_align (
    .doutb (doutb),
    .off   (trk[RAM_LAT].off),
    .size  (trk[RAM_LAT].size),
    .sgn   (trk[RAM_LAT].sgn),
    .data  (align_data)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      addra        <= '0;
      addrb        <= '0;
      dina         <= '0;
      wea          <= '0;
      misalign_err <= 1'b0;
      ld_valid     <= 1'b0;
      ld_rd        <= '0;
      ld_data      <= '0;
      for (int i = 0; i <= RAM_LAT; i++) trk[i] <= '0;
      for (int i = 0; i < RAM_LAT; i++) begin
        st_v[i]   <= 1'b0;
        st_idx[i] <= '0;
      end
    end else begin
      wea          <= '0;
      misalign_err <= 1'b0;
      if (accept) begin
        if (mis) begin
          misalign_err <= 1'b1;
        end else begin
          addra <= {3'b000, req_idx};
          addrb <= {3'b000, req_idx};
          if (req_store) begin
            wea  <= lane_mask(req_sz, req_off);
            dina <= {32'h0, req_wdata} << {req_off, 3'b000};
          end
        end
      end

      trk[0].valid <= accept & ~mis & ~req_store;
      trk[0].off   <= req_off;
      trk[0].size  <= req_sz;
      trk[0].sgn   <= req_signed;
      trk[0].rd    <= req_rd;
      for (int i = 1; i <= RAM_LAT; i++) trk[i] <= trk[i-1];

      st_v[0]   <= accept & ~mis & req_store;
      st_idx[0] <= req_idx;
      for (int i = 1; i < RAM_LAT; i++) begin
        st_v[i]   <= st_v[i-1];
        st_idx[i] <= st_idx[i-1];
      end

      // Result registers only move when a load retires, so they hold otherwise.
      ld_valid <= trk[RAM_LAT].valid;
      if (trk[RAM_LAT].valid) begin
        ld_rd   <= trk[RAM_LAT].rd;
        ld_data <= align_data;
      end
    end
  end

endmodule
